// File: rtl/l2_pkg.sv
// l2_pkg: defaults and types shared by the L2 host-request arbiter slice.
package l2_pkg;
  localparam int nstrm_dflt      = 8;
  localparam int addr_width_dflt = 64;
  localparam int strm_width_dflt = $clog2(nstrm_dflt);

  // Stream index carried as the host request tag.
  typedef logic [strm_width_dflt-1:0] tag_t;
endpackage

// File: rtl/l2_host_arb_if.sv
// l2_host_arb_if: stream request, host request and host response channels of
// the L2 host arbiter, plus read-only debug taps of its internal state.
//
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clk edge where valid and ready are both high; once valid is raised the
// source holds valid and its payload unchanged until that transfer; ready may
// depend combinationally on valid, but valid never depends on ready.
interface l2_host_arb_if import l2_pkg::*; #(
  parameter int nstrm      = nstrm_dflt,
  parameter int addr_width = addr_width_dflt,
  parameter int max_out    = 32
);
  localparam int strm_width = $clog2(nstrm);
  localparam int out_width  = $clog2(max_out + 1);

  logic [nstrm-1:0]            i_req_v;
  logic [nstrm-1:0]            i_req_r;
  logic [nstrm*addr_width-1:0] i_req_ea;
  logic                        o_req_v;
  logic                        o_req_r;
  logic [addr_width-1:0]       o_req_ea;
  logic [strm_width-1:0]       o_req_tag;
  logic                        i_rsp_v;
  logic                        i_rsp_r;
  logic [strm_width-1:0]       i_rsp_tag;
  logic [nstrm-1:0]            o_rsp_v;
  logic                        o_idle;
  logic                        o_err;
  logic [strm_width-1:0]       dbg_rr_ptr;
  logic [out_width-1:0]        dbg_outst;

  // Arbiter side.
  modport slave (
    input  i_req_v, i_req_ea, o_req_r, i_rsp_v, i_rsp_tag,
    output i_req_r, o_req_v, o_req_ea, o_req_tag, i_rsp_r, o_rsp_v,
    output o_idle, o_err, dbg_rr_ptr, dbg_outst
  );

  // Environment side: the streams and the host.
  modport master (
    output i_req_v, i_req_ea, o_req_r, i_rsp_v, i_rsp_tag,
    input  i_req_r, o_req_v, o_req_ea, o_req_tag, i_rsp_r, o_rsp_v,
    input  o_idle, o_err, dbg_rr_ptr, dbg_outst
  );
endinterface

// File: rtl/l2_rr_arb.sv
// l2_rr_arb: round-robin pick of the first requester at or after rr_ptr.
module l2_rr_arb import l2_pkg::*; #(
  parameter int  nstrm      = nstrm_dflt,
  localparam int strm_width = $clog2(nstrm)
) (
  input  logic [nstrm-1:0]      req,
  input  logic [strm_width-1:0] rr_ptr,
  output logic [nstrm-1:0]      gnt,
  output logic [strm_width-1:0] gnt_idx,
  output logic                  gnt_v
);
  // Scan upward from rr_ptr with wrap and keep the first hit.
  always_comb begin
    int k;
    gnt     = '0;
    gnt_idx = '0;
    gnt_v   = 1'b0;
    k       = 0;
    for (int i = 0; i < nstrm; i++) begin
      k = (int'(rr_ptr) + i) % nstrm;
      if (!gnt_v && req[k]) begin
        gnt_v   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = strm_width'(k);
      end
    end
  end
endmodule

// File: rtl/l2_host_arb.sv
// l2_host_arb: shares one host request channel among nstrm L2 stream pointers
// with round-robin grant, max_out outstanding-request credits and response
// fan-out. Define L2_HOST_ARB_OREG_EN to put a one-entry output register
// between the arbiter and the host port (grant-to-host latency 1).
module l2_host_arb import l2_pkg::*; #(
  parameter int  nstrm      = nstrm_dflt,
  parameter int  addr_width = addr_width_dflt,
  parameter int  max_out    = 32,
  localparam int strm_width = $clog2(nstrm),
  localparam int out_width  = $clog2(max_out + 1)
) (
  input logic          clk,
  input logic          reset,
  l2_host_arb_if.slave bus
);
  localparam logic [out_width-1:0]  max_out_c = out_width'(max_out);
  localparam logic [strm_width-1:0] last_idx  = strm_width'(nstrm - 1);
  localparam logic [nstrm-1:0]      one_c     = nstrm'(1);

  logic [strm_width-1:0] rr_ptr;
  logic [out_width-1:0]  outst, outst_nxt;
  logic                  idle_q, err_q;
  logic                  credit_ok, accept;
  logic [nstrm-1:0]      arb_req, arb_gnt;
  logic [strm_width-1:0] arb_idx, acc_idx;
  logic                  arb_v;
  logic                  rsp_bad, rsp_ok;

  // No new grant while credits are exhausted or reset is held.
  assign credit_ok = (outst != max_out_c);
  assign arb_req   = bus.i_req_v & {nstrm{credit_ok & reset}};

  l2_rr_arb #(.nstrm(nstrm)) u_rr_arb (
    .req     (arb_req),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_v   (arb_v)
  );

`ifdef L2_HOST_ARB_OREG_EN
  logic                  oreg_v;
  logic [addr_width-1:0] oreg_ea;
  logic [strm_width-1:0] oreg_tag;

  // A grant is taken whenever the register is empty or drains this cycle.
  assign accept      = arb_v & (~oreg_v | bus.o_req_r);
  assign acc_idx     = arb_idx;
  assign bus.i_req_r = accept ? arb_gnt : '0;
  assign bus.o_req_v   = oreg_v;
  assign bus.o_req_ea  = oreg_ea;
  assign bus.o_req_tag = oreg_tag;

  // Output register: load on accepted grant, empty on host drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oreg_v   <= 1'b0;
      oreg_ea  <= '0;
      oreg_tag <= '0;
    end else if (accept) begin
      oreg_v   <= 1'b1;
      oreg_ea  <= bus.i_req_ea[arb_idx*addr_width +: addr_width];
      oreg_tag <= arb_idx;
    end else if (bus.o_req_r) begin
      oreg_v   <= 1'b0;
    end
  end
`else
  logic                  lock_v;
  logic [strm_width-1:0] lock_idx;
  logic                  sel_v;
  logic [strm_width-1:0] sel_idx;
  logic [nstrm-1:0]      sel_gnt;

  // A stalled grant stays locked so a newly raised higher-priority stream
  // cannot change tag/EA under the host.
  always_comb begin
    sel_v   = arb_v;
    sel_idx = arb_idx;
    sel_gnt = arb_gnt;
    if (lock_v) begin
      sel_v   = bus.i_req_v[lock_idx];
      sel_idx = lock_idx;
      sel_gnt = one_c << lock_idx;
    end
  end

  assign accept        = sel_v & bus.o_req_r;
  assign acc_idx       = sel_idx;
  assign bus.i_req_r   = accept ? sel_gnt : '0;
  assign bus.o_req_v   = sel_v;
  assign bus.o_req_ea  = bus.i_req_ea[sel_idx*addr_width +: addr_width];
  assign bus.o_req_tag = sel_idx;

  // Remember a grant the host did not take this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_v   <= 1'b0;
      lock_idx <= '0;
    end else begin
      lock_v   <= sel_v & ~bus.o_req_r;
      lock_idx <= sel_idx;
    end
  end
`endif

  // Responses are always taken; bad ones only raise the error flag.
  assign rsp_bad     = bus.i_rsp_v & ((outst == '0) | (int'(bus.i_rsp_tag) >= nstrm));
  assign rsp_ok      = bus.i_rsp_v & ~rsp_bad;
  assign bus.i_rsp_r = 1'b1;
  assign bus.o_rsp_v = rsp_ok ? (one_c << bus.i_rsp_tag) : '0;

  // Credit count: +1 per accepted grant, -1 per good response.
  always_comb begin
    outst_nxt = outst;
    if (accept && !rsp_ok)      outst_nxt = outst + 1'b1;
    else if (!accept && rsp_ok) outst_nxt = outst - 1'b1;
  end

  // Pointer, credits, idle and sticky error state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      outst  <= '0;
      idle_q <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      if (accept) rr_ptr <= (acc_idx == last_idx) ? '0 : acc_idx + 1'b1;
      outst  <= outst_nxt;
      idle_q <= (outst_nxt == '0);
      err_q  <= err_q | rsp_bad;
    end
  end

  assign bus.o_idle     = idle_q;
  assign bus.o_err      = err_q;
  assign bus.dbg_rr_ptr = rr_ptr;
  assign bus.dbg_outst  = outst;
endmodule
